// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage with the MEM/WB pipeline register.
// Loads and stores go out on a request/acknowledge data-memory port. The
// stage stalls upstream while an access is outstanding. Other instructions
// reach MEM/WB one cycle after they are presented.
//
// Handshake: mem_req rises on the edge that accepts a memory op. mem_req,
// mem_we, mem_addr, mem_wdata and mem_byte_en then stay constant until the
// edge that ends the access. The access ends on the first cycle with
// mem_ack = 1; mem_rdata is sampled in that same cycle. If no ack arrives,
// the access is forced to end after TIMEOUT cycles. Upstream keeps its
// EX/MEM contents while stall = 1 and moves on at an edge where stall = 0.
module mem_access_stage #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [63:0] alu_result,
  input  logic [63:0] store_data,
  input  logic [63:0] noBrPC,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        byte_op,
  input  logic        MemtoReg,
  input  logic        BL_op,
  input  logic        RegWrite,
  input  logic [4:0]  Rd,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_byte_en,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic        wb_valid,
  output logic [63:0] wb_alu_result,
  output logic [63:0] wb_read_data,
  output logic [63:0] wb_noBrPC,
  output logic        wb_MemtoReg,
  output logic        wb_BL_op,
  output logic        wb_RegWrite,
  output logic [4:0]  wb_Rd,
  output logic        misalign_err,
  output logic        timeout_err
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  wait_cnt;

  // Fields captured when a memory op is accepted, replayed into MEM/WB on completion
  logic [63:0] lat_alu;
  logic [63:0] lat_noBrPC;
  logic        lat_MemtoReg;
  logic        lat_BL_op;
  logic        lat_RegWrite;
  logic [4:0]  lat_Rd;
  logic        lat_byte;
  logic        lat_load;

  logic        is_mem;
  logic        ack_done;
  logic        to_done;
  logic        done;
  logic [63:0] load_data;

  assign is_mem   = MemRead | MemWrite;
  assign ack_done = (state == ACCESS) && mem_ack;
  assign to_done  = (state == ACCESS) && !mem_ack && (wait_cnt == LAST_WAIT);
  assign done     = ack_done | to_done;

  // Stall while a new memory op is being accepted or an access is still pending
  always_comb begin
    stall = 1'b0;
    if (state == IDLE) stall = in_valid & is_mem;
    else               stall = !done;
  end

  // Load data: pick the addressed byte (zero-extended) or the full doubleword.
  // A timed-out or store access writes zero into read_data.
  always_comb begin
    load_data = 64'd0;
    if (ack_done && lat_load) begin
      if (lat_byte) load_data = {56'd0, mem_rdata[{lat_alu[2:0], 3'b000} +: 8]};
      else          load_data = mem_rdata;
    end
  end

  // Stage FSM, memory port registers and MEM/WB register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      wait_cnt      <= 8'd0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= 64'd0;
      mem_wdata     <= 64'd0;
      mem_byte_en   <= 8'd0;
      lat_alu       <= 64'd0;
      lat_noBrPC    <= 64'd0;
      lat_MemtoReg  <= 1'b0;
      lat_BL_op     <= 1'b0;
      lat_RegWrite  <= 1'b0;
      lat_Rd        <= 5'd0;
      lat_byte      <= 1'b0;
      lat_load      <= 1'b0;
      wb_valid      <= 1'b0;
      wb_alu_result <= 64'd0;
      wb_read_data  <= 64'd0;
      wb_noBrPC     <= 64'd0;
      wb_MemtoReg   <= 1'b0;
      wb_BL_op      <= 1'b0;
      wb_RegWrite   <= 1'b0;
      wb_Rd         <= 5'd0;
      misalign_err  <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt <= 8'd0;
          if (in_valid && is_mem) begin
            state        <= ACCESS;
            mem_req      <= 1'b1;
            mem_we       <= MemWrite;
            mem_addr     <= byte_op ? alu_result : {alu_result[63:3], 3'b000};
            mem_byte_en  <= byte_op ? (8'b1 << alu_result[2:0]) : 8'hFF;
            mem_wdata    <= byte_op ? {8{store_data[7:0]}} : store_data;
            lat_alu      <= alu_result;
            lat_noBrPC   <= noBrPC;
            lat_MemtoReg <= MemtoReg;
            lat_BL_op    <= BL_op;
            lat_RegWrite <= RegWrite;
            lat_Rd       <= Rd;
            lat_byte     <= byte_op;
            lat_load     <= MemRead & ~MemWrite;
            if (!byte_op && (alu_result[2:0] != 3'b000)) misalign_err <= 1'b1;
            wb_valid     <= 1'b0;
            wb_RegWrite  <= 1'b0;
          end else if (in_valid) begin
            wb_valid      <= 1'b1;
            wb_alu_result <= alu_result;
            wb_read_data  <= 64'd0;
            wb_noBrPC     <= noBrPC;
            wb_MemtoReg   <= MemtoReg;
            wb_BL_op      <= BL_op;
            wb_RegWrite   <= RegWrite;
            wb_Rd         <= Rd;
          end else begin
            wb_valid    <= 1'b0;
            wb_RegWrite <= 1'b0;
          end
        end
        ACCESS: begin
          if (done) begin
            state         <= IDLE;
            mem_req       <= 1'b0;
            wait_cnt      <= 8'd0;
            wb_valid      <= 1'b1;
            wb_alu_result <= lat_alu;
            wb_read_data  <= load_data;
            wb_noBrPC     <= lat_noBrPC;
            wb_MemtoReg   <= lat_MemtoReg;
            wb_BL_op      <= lat_BL_op;
            wb_RegWrite   <= lat_RegWrite;
            wb_Rd         <= lat_Rd;
            if (to_done) timeout_err <= 1'b1;
          end else begin
            wait_cnt    <= wait_cnt + 8'd1;
            wb_valid    <= 1'b0;
            wb_RegWrite <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a table of non-memory vectors, a table
// of load/store vectors with scripted ack latency, and hand-written sequences
// for timeout, ack-in-IDLE and asynchronous reset mid-access.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [63:0] alu_result;
  logic [63:0] store_data;
  logic [63:0] noBrPC;
  logic        MemRead;
  logic        MemWrite;
  logic        byte_op;
  logic        MemtoReg;
  logic        BL_op;
  logic        RegWrite;
  logic [4:0]  Rd;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_byte_en;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        wb_valid;
  logic [63:0] wb_alu_result;
  logic [63:0] wb_read_data;
  logic [63:0] wb_noBrPC;
  logic        wb_MemtoReg;
  logic        wb_BL_op;
  logic        wb_RegWrite;
  logic [4:0]  wb_Rd;
  logic        misalign_err;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  mem_access_stage #(.TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .alu_result(alu_result),
    .store_data(store_data), .noBrPC(noBrPC), .MemRead(MemRead),
    .MemWrite(MemWrite), .byte_op(byte_op), .MemtoReg(MemtoReg),
    .BL_op(BL_op), .RegWrite(RegWrite), .Rd(Rd), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_byte_en(mem_byte_en), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_alu_result(wb_alu_result),
    .wb_read_data(wb_read_data), .wb_noBrPC(wb_noBrPC),
    .wb_MemtoReg(wb_MemtoReg), .wb_BL_op(wb_BL_op),
    .wb_RegWrite(wb_RegWrite), .wb_Rd(wb_Rd), .misalign_err(misalign_err),
    .timeout_err(timeout_err)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, want finish)");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        v;
    logic [63:0] alu;
    logic [63:0] pc;
    logic        m2r;
    logic        bl;
    logic        rw;
    logic [4:0]  rd;
    logic        e_v;
    logic [63:0] e_alu;
    logic [63:0] e_pc;
    logic        e_m2r;
    logic        e_bl;
    logic        e_rw;
    logic [4:0]  e_rd;
  } alu_vec_t;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] sd;
    logic        rd;
    logic        wr;
    logic        byt;
    logic        m2r;
    logic        rw;
    logic [4:0]  rdn;
    logic [63:0] rdata;
    int          delay;
    logic [63:0] e_addr;
    logic [7:0]  e_be;
    logic [63:0] e_wdata;
    logic        e_we;
    logic [63:0] e_rdata;
    logic        e_mis;
  } mem_vec_t;

  alu_vec_t at[5];
  mem_vec_t mt[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    in_valid = 1'b0; alu_result = 64'd0; store_data = 64'd0; noBrPC = 64'd0;
    MemRead = 1'b0; MemWrite = 1'b0; byte_op = 1'b0; MemtoReg = 1'b0;
    BL_op = 1'b0; RegWrite = 1'b0; Rd = 5'd0; mem_ack = 1'b0; mem_rdata = 64'd0;
  endtask

  // Drive one memory op, ack it after t.delay waiting ACCESS cycles, check port and MEM/WB
  task automatic do_mem(input mem_vec_t t, input int idx);
    int nstall;
    @(negedge clk);
    in_valid = 1'b1; alu_result = t.addr; store_data = t.sd;
    noBrPC = 64'h8000 + 64'(idx); MemRead = t.rd; MemWrite = t.wr;
    byte_op = t.byt; MemtoReg = t.m2r; BL_op = 1'b0; RegWrite = t.rw;
    Rd = t.rdn; mem_ack = 1'b0; mem_rdata = 64'd0;
    #1 chk("mem_stall_idle", stall, 1);
    nstall = 1;
    @(posedge clk); #1;
    chk("mem_req_set", mem_req, 1);
    chk("mem_addr", mem_addr, t.e_addr);
    chk("mem_byte_en", mem_byte_en, t.e_be);
    chk("mem_wdata", mem_wdata, t.e_wdata);
    chk("mem_we", mem_we, t.e_we);
    chk("wb_bubble_valid", wb_valid, 0);
    for (int k = 0; k < t.delay; k++) begin
      @(negedge clk); #1;
      if (stall) nstall++;
    end
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = t.rdata;
    #1 chk("mem_stall_ack", stall, 0);
    chk("mem_stall_cycles", 64'(nstall), 64'(t.delay + 1));
    chk("mem_addr_held", mem_addr, t.e_addr);
    @(posedge clk); #1;
    chk("wb_valid_done", wb_valid, 1);
    chk("wb_read_data", wb_read_data, t.e_rdata);
    chk("wb_alu_result_mem", wb_alu_result, t.addr);
    chk("wb_noBrPC_mem", wb_noBrPC, 64'h8000 + 64'(idx));
    chk("wb_RegWrite_mem", wb_RegWrite, t.rw);
    chk("wb_MemtoReg_mem", wb_MemtoReg, t.m2r);
    chk("wb_Rd_mem", wb_Rd, t.rdn);
    chk("mem_req_drop", mem_req, 0);
    chk("misalign_err", misalign_err, t.e_mis);
    clear_inputs();
  endtask

  initial begin
    int nacc;
    logic got;

    //           v  alu                    pc          m2r bl rw rd   e_v e_alu                  e_pc        m2r bl rw rd
    at[0] = '{1, 64'h10,                64'h4,       0, 0, 1, 3,   1, 64'h10,                64'h4,       0, 0, 1, 3};
    at[1] = '{0, 64'h999,               64'h777,     1, 1, 1, 9,   0, 64'h10,                64'h4,       0, 0, 0, 3};
    at[2] = '{1, 64'h55,                64'h1004,    0, 1, 1, 30,  1, 64'h55,                64'h1004,    0, 1, 1, 30};
    at[3] = '{1, 64'hFFFFFFFFFFFFFFF0,  64'h2000,    1, 0, 0, 31,  1, 64'hFFFFFFFFFFFFFFF0,  64'h2000,    1, 0, 0, 31};
    at[4] = '{0, 64'h1234,              64'h5678,    0, 1, 1, 2,   0, 64'hFFFFFFFFFFFFFFF0,  64'h2000,    1, 0, 0, 31};

    //          addr     sd                     rd wr by m2r rw rdn rdata                  dly e_addr   be     e_wdata                e_we e_rdata               mis
    mt[0] = '{64'h100, 64'h0,                 1, 0, 0, 1, 1, 5,  64'hDEADBEEFCAFEF00D, 3, 64'h100, 8'hFF, 64'h0,                 0, 64'hDEADBEEFCAFEF00D, 0};
    mt[1] = '{64'h203, 64'hAB,                0, 1, 1, 0, 0, 6,  64'h1111,             0, 64'h203, 8'h08, 64'hABABABABABABABAB, 1, 64'h0,                0};
    mt[2] = '{64'h105, 64'h0,                 1, 0, 1, 1, 1, 7,  64'h0011223344556677, 1, 64'h105, 8'h20, 64'h0,                 0, 64'h22,               0};
    mt[3] = '{64'h300, 64'h0123456789ABCDEF,  1, 1, 0, 0, 0, 8,  64'h5555,             2, 64'h300, 8'hFF, 64'h0123456789ABCDEF, 1, 64'h0,                0};
    mt[4] = '{64'h10C, 64'h0,                 1, 0, 0, 1, 1, 9,  64'h55,               0, 64'h108, 8'hFF, 64'h0,                 0, 64'h55,               1};
    mt[5] = '{64'h7,   64'h0,                 1, 0, 1, 1, 1, 10, 64'hFF00000000000000, 2, 64'h7,   8'h80, 64'h0,                 0, 64'hFF,               1};

    // Reset
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_alu_result", wb_alu_result, 0);
    chk("rst_errs", {misalign_err, timeout_err}, 0);
    chk("rst_stall", stall, 0);
    @(negedge clk);
    reset = 1'b0;

    // Non-memory pass-through and bubbles
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = at[i].v; alu_result = at[i].alu; noBrPC = at[i].pc;
      MemtoReg = at[i].m2r; BL_op = at[i].bl; RegWrite = at[i].rw; Rd = at[i].rd;
      MemRead = 1'b0; MemWrite = 1'b0;
      #1 chk("alu_stall", stall, 0);
      @(posedge clk); #1;
      chk("alu_wb_valid", wb_valid, at[i].e_v);
      chk("alu_wb_alu_result", wb_alu_result, at[i].e_alu);
      chk("alu_wb_noBrPC", wb_noBrPC, at[i].e_pc);
      chk("alu_wb_ctrl", {wb_MemtoReg, wb_BL_op, wb_RegWrite}, {at[i].e_m2r, at[i].e_bl, at[i].e_rw});
      chk("alu_wb_Rd", wb_Rd, at[i].e_rd);
      chk("alu_wb_read_data", wb_read_data, 0);
    end
    clear_inputs();

    // Loads and stores
    for (int i = 0; i < 6; i++) do_mem(mt[i], i);

    // Timeout: no ack ever arrives
    @(negedge clk);
    in_valid = 1'b1; alu_result = 64'h400; MemRead = 1'b1; MemtoReg = 1'b1;
    RegWrite = 1'b1; Rd = 5'd7; mem_rdata = 64'hFFFF;
    #1 chk("to_err_before", timeout_err, 0);
    @(posedge clk); #1;
    nacc = 0;
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk); #1;
      nacc++;
      if (!stall) got = 1'b1;
      else @(posedge clk);
    end
    chk("to_access_cycles", 64'(nacc), 64);
    @(posedge clk); #1;
    chk("to_err", timeout_err, 1);
    chk("to_wb_valid", wb_valid, 1);
    chk("to_wb_read_data", wb_read_data, 0);
    chk("to_wb_alu_result", wb_alu_result, 64'h400);
    chk("to_mem_req", mem_req, 0);
    clear_inputs();
    @(negedge clk); #1;
    chk("to_idle_stall", stall, 0);

    // mem_ack in IDLE has no effect
    mem_ack = 1'b1; mem_rdata = 64'h1234;
    @(posedge clk); #1;
    chk("idle_ack_wb_valid", wb_valid, 0);
    chk("idle_ack_mem_req", mem_req, 0);
    chk("idle_ack_to_err", timeout_err, 1);
    mem_ack = 1'b0;

    // Asynchronous reset in the middle of an access
    @(negedge clk);
    in_valid = 1'b1; alu_result = 64'h500; store_data = 64'h77; MemWrite = 1'b1; Rd = 5'd9;
    @(posedge clk); #1;
    chk("ar_mem_req_set", mem_req, 1);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("ar_mem_req", mem_req, 0);
    chk("ar_wb_alu_result", wb_alu_result, 0);
    chk("ar_wb_noBrPC", wb_noBrPC, 0);
    chk("ar_wb_misc", {wb_valid, wb_MemtoReg, wb_BL_op, wb_RegWrite, wb_Rd}, 0);
    chk("ar_errs", {misalign_err, timeout_err}, 0);
    chk("ar_mem_addr", mem_addr, 0);
    clear_inputs();
    @(negedge clk);
    reset = 1'b0;
    #1 chk("ar_stall", stall, 0);
    @(negedge clk);
    in_valid = 1'b1; alu_result = 64'h42; RegWrite = 1'b1; Rd = 5'd4;
    @(posedge clk); #1;
    chk("ar_after_valid", wb_valid, 1);
    chk("ar_after_alu", wb_alu_result, 64'h42);
    clear_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline stage 4 (memory access) plus the MEM/WB pipeline register.
- Takes EX/MEM results and performs LDUR/LDURB/STUR/STURB through a request/acknowledge data-memory port, stalling the pipeline while an access is outstanding.
- Registers alu_result, read_data, noBrPC and the control bits that the write-back stage consumes.
- Non-memory instructions pass through with 1-cycle latency.

Parameters:
TIMEOUT, 64, max cycles in ACCESS without mem_ack before forced completion (1..255)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high
in_valid  input  1  EX/MEM holds a valid instruction
alu_result  input  64  ALU result / effective address
store_data  input  64  register data for stores
noBrPC  input  64  PC+4 for BL
MemRead  input  1  load
MemWrite  input  1  store
byte_op  input  1  1 = byte access (LDURB/STURB), 0 = doubleword
MemtoReg  input  1  pass-through to WB
BL_op  input  1  pass-through to WB
RegWrite  input  1  pass-through to WB
Rd  input  5  destination register
stall  output  1  upstream must hold EX/MEM contents (combinational)
mem_req  output  1  memory request, registered
mem_we  output  1  1 = write
mem_addr  output  64  access address
mem_wdata  output  64  write data, lane-aligned
mem_byte_en  output  8  byte lane enables
mem_ack  input  1  access complete; mem_rdata valid this cycle
mem_rdata  input  64  read data
wb_valid  output  1  MEM/WB holds a valid instruction
wb_alu_result  output  64  to write-back stage
wb_read_data  output  64  to write-back stage
wb_noBrPC  output  64  to write-back stage
wb_MemtoReg  output  1  to write-back stage
wb_BL_op  output  1  to write-back stage
wb_RegWrite  output  1  to write-back stage
wb_Rd  output  5  to write-back stage
misalign_err  output  1  sticky: doubleword access with addr[2:0] != 0
timeout_err  output  1  sticky: access hit TIMEOUT

Behaviour:
- Reset (async):
  - state IDLE, wait counter 0.
  - All registered outputs 0, including mem_req, wb_*, mem_* and both error flags.
  - Asserting reset mid-access drops mem_req immediately and abandons the access.
- FSM states: IDLE, ACCESS.
- IDLE, in_valid and neither MemRead nor MemWrite:
  - Next edge loads MEM/WB with the inputs; wb_read_data = 0, wb_valid = 1.
  - stall = 0.
- IDLE, in_valid and (MemRead or MemWrite):
  - stall = 1.
  - Next edge: go to ACCESS, set mem_req = 1, latch mem_we = MemWrite, address, data, enables and the pass-through fields.
  - MEM/WB loads a bubble: wb_valid = 0, wb_RegWrite = 0, other wb_* held.
- IDLE, !in_valid: MEM/WB loads a bubble.
- MemRead and MemWrite both set: treat as a store.
- Address and lanes:
  - Byte op: mem_addr = alu_result, mem_byte_en = 1 << addr[2:0], mem_wdata = store_data[7:0] replicated in all 8 lanes.
  - Doubleword op: mem_addr = alu_result with bits [2:0] cleared, mem_byte_en = 8'hFF, mem_wdata = store_data.
  - If addr[2:0] != 0 on a doubleword op, set misalign_err; the access still proceeds aligned.
- ACCESS:
  - mem_req and mem_addr/we/wdata/byte_en are held stable; the wait counter increments each cycle.
  - stall = !mem_ack.
- ACCESS, mem_ack = 1:
  - Next edge loads MEM/WB with the latched fields and wb_valid = 1.
  - Load read data: byte op gives zero-extended mem_rdata byte at the lane addr[2:0]; doubleword gives mem_rdata. Stores give wb_read_data = 0.
  - mem_req drops, counter clears, state returns to IDLE.
  - Upstream advances on the same edge because stall = 0.
- ACCESS, counter reaches TIMEOUT-1 with no ack:
  - Complete as if acked with mem_rdata treated as 0.
  - Set timeout_err.
  - stall = 0 in that cycle.
- mem_ack is ignored in IDLE.
- Error flags clear only on reset.
- Minimum memory-op latency: 2 cycles (IDLE→ACCESS, ack in the first ACCESS cycle).

Test Plan:
- ADD pass-through: in_valid = 1, alu_result = 0x10, RegWrite = 1, Rd = 3, no memory op → one edge later wb_valid = 1, wb_alu_result = 0x10, wb_Rd = 3, stall never asserted.
- LDUR: alu_result = 0x100, MemRead = 1, MemtoReg = 1; mem_ack arrives 3 cycles after mem_req with mem_rdata = 0xDEADBEEFCAFEF00D → mem_addr = 0x100, mem_byte_en = 0xFF, stall high for 4 cycles; then wb_read_data = 0xDEADBEEFCAFEF00D and wb_valid = 1.
- STURB: alu_result = 0x203, store_data = 0xAB, MemWrite = 1; ack immediately → mem_we = 1, mem_byte_en = 0x08, mem_wdata = 0xABABABABABABABAB; wb_RegWrite = 0 as passed, wb_read_data = 0.
- LDURB: alu_result = 0x105, mem_rdata = 0x0011223344556677 → wb_read_data = 0x22.
- Misaligned LDUR at 0x10C → mem_addr = 0x108, misalign_err = 1 and stays 1.
- No ack for 64 cycles → timeout_err = 1, wb_read_data = 0, state IDLE; a reset asserted mid-ACCESS in a separate run drops mem_req asynchronously and clears all wb_* outputs.
